// File: rtl/syn_fetch_queue.sv
// -----------------------------------------------------------------------------
// syn_fetch_queue
//
// Instruction fetch stage with a small prefetch queue. Owns the fetch PC,
// drives the combinational instruction-memory address, buffers fetched
// instructions together with their PC+1 (word address) in a FIFO and presents
// the head to decode through a valid/ready handshake. Decode stalls are
// absorbed by the queue; a redirect (load_pc) flushes it and restarts fetch
// at pc_new.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   : with an empty queue and no redirect, the head is driven
//               straight from im_inst / fetch_pc+1 (fetch-to-decode latency 0);
//               a bypassed instruction accepted by decode is never written.
//   undefined : every instruction passes through storage (latency 1).
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   en         global enable; 0 freezes all state
//   load_pc    redirect request (jump/branch taken in EX)
//   pc_new     redirect target, word address
//   im_addr    instruction memory address (= fetch_pc)
//   im_inst    instruction memory data, combinational from im_addr
//   out_valid  queue head valid for decode
//   out_ready  decode accepts the head this cycle
//   out_inst   head instruction, 0 (NOP) when out_valid=0
//   out_pc_4   head PC+1 (word address), 0 when out_valid=0
//   fq_count   number of occupied queue entries
// -----------------------------------------------------------------------------
module syn_fetch_queue #(
    parameter int AddrBit = 10,
    parameter int Depth   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load_pc,
    input  logic [AddrBit-1:0]      pc_new,
    output logic [AddrBit-1:0]      im_addr,
    input  logic [31:0]             im_inst,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_inst,
    output logic [AddrBit-1:0]      out_pc_4,
    output logic [$clog2(Depth):0]  fq_count
);

    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(Depth);

    // Control state (reset) and storage (not reset)
    logic [AddrBit-1:0] fetch_pc;
    logic [AddrBit-1:0] fetch_pc_4;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    logic [31:0]        inst_q [Depth];
    logic [AddrBit-1:0] pc4_q  [Depth];

    logic q_empty;
    logic q_full;
    logic q_pop;
    logic push;
    logic byp_take;
    logic advance;

    assign fetch_pc_4 = fetch_pc + AddrBit'(1);
    assign im_addr    = fetch_pc;
    assign fq_count   = count;
    assign q_empty    = (count == '0);
    assign q_full     = (count == DEPTH_C);

    // Head selection
`ifdef FETCH_BYPASS_EN
    logic byp_act;
    assign byp_act  = q_empty && !load_pc;
    // A bypassed instruction accepted by decode is consumed without a write.
    assign byp_take = en && byp_act && out_ready;

    always_comb begin
        out_valid = 1'b0;
        out_inst  = '0;
        out_pc_4  = '0;
        if (byp_act) begin
            out_valid = en;
            if (en) begin
                out_inst = im_inst;
                out_pc_4 = fetch_pc_4;
            end
        end else if (!q_empty) begin
            out_valid = 1'b1;
            out_inst  = inst_q[rd_ptr];
            out_pc_4  = pc4_q[rd_ptr];
        end
    end
`else
    assign byp_take = 1'b0;

    always_comb begin
        out_valid = !q_empty;
        out_inst  = '0;
        out_pc_4  = '0;
        if (!q_empty) begin
            out_inst = inst_q[rd_ptr];
            out_pc_4 = pc4_q[rd_ptr];
        end
    end
`endif

    // Pop only ever comes from stored entries; a non-empty queue is always
    // valid, so out_valid need not be re-tested here. A redirect discards it.
    assign q_pop   = en && !load_pc && !q_empty && out_ready;
    // A full queue still accepts a new entry when the head leaves this edge.
    assign push    = en && !load_pc && !byp_take && (!q_full || q_pop);
    assign advance = push || byp_take;

    // Control update: rst > !en > load_pc > push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (en) begin
            if (load_pc) begin
                fetch_pc <= pc_new;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (advance) fetch_pc <= fetch_pc_4;
                if (push)    wr_ptr   <= wr_ptr + PW'(1);
                if (q_pop)   rd_ptr   <= rd_ptr + PW'(1);
                case ({push, q_pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr] <= im_inst;
            pc4_q[wr_ptr]  <= fetch_pc_4;
        end
    end

endmodule
